// File: rtl/vx_execute_packetizer_pkg.sv
// Shared types for the execute packetizer: the full-warp issue packet, the
// lane-sliced execute packet, the FSM state, and the slice builder.
package vx_execute_packetizer_pkg;

    localparam int unsigned NUM_THREADS   = 8;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned EXEC_LANES    = 2;
    localparam int unsigned NUM_PKTS      = NUM_THREADS / EXEC_LANES;
    localparam int unsigned PID_WIDTH     = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int unsigned UUID_WIDTH    = 44;
    localparam int unsigned WID_WIDTH     = 2;
    localparam int unsigned OP_TYPE_WIDTH = 4;
    localparam int unsigned OP_ARGS_WIDTH = 16;
    localparam int unsigned RD_WIDTH      = 5;
    localparam int unsigned TID_WIDTH     = $clog2(NUM_THREADS);
    localparam int unsigned INFL_WIDTH    = 4;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                  uuid;
        logic [WID_WIDTH-1:0]                   wid;
        logic [NUM_THREADS-1:0]                 tmask;
        logic [XLEN-1:0]                        pc;
        logic [OP_TYPE_WIDTH-1:0]               op_type;
        logic [OP_ARGS_WIDTH-1:0]               op_args;
        logic                                   wb;
        logic [RD_WIDTH-1:0]                    rd;
        logic [TID_WIDTH-1:0]                   tid;
        logic [NUM_THREADS-1:0][XLEN-1:0]       rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]       rs2_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]       rs3_data;
        logic [INFL_WIDTH-1:0]                  infl_id;
    } issue_data_t;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                  uuid;
        logic [WID_WIDTH-1:0]                   wid;
        logic [EXEC_LANES-1:0]                  tmask;
        logic [XLEN-1:0]                        pc;
        logic [OP_TYPE_WIDTH-1:0]               op_type;
        logic [OP_ARGS_WIDTH-1:0]               op_args;
        logic                                   wb;
        logic [RD_WIDTH-1:0]                    rd;
        logic [TID_WIDTH-1:0]                   tid;
        logic [EXEC_LANES-1:0][XLEN-1:0]        rs1_data;
        logic [EXEC_LANES-1:0][XLEN-1:0]        rs2_data;
        logic [EXEC_LANES-1:0][XLEN-1:0]        rs3_data;
        logic [INFL_WIDTH-1:0]                  infl_id;
        logic [PID_WIDTH-1:0]                   pid;
        logic                                   sop;
        logic                                   eop;
    } execute_data_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pkt_state_e;

    // Build execute slice `pid` of a held warp; scalar fields pass through unchanged.
    function automatic execute_data_t make_slice(
        input issue_data_t           d,
        input logic [PID_WIDTH-1:0]  pid,
        input logic                  sop,
        input logic                  eop
    );
        execute_data_t e;
        e          = '0;
        e.uuid     = d.uuid;
        e.wid      = d.wid;
        e.pc       = d.pc;
        e.op_type  = d.op_type;
        e.op_args  = d.op_args;
        e.wb       = d.wb;
        e.rd       = d.rd;
        e.tid      = d.tid;
        e.infl_id  = d.infl_id;
        e.pid      = pid;
        e.sop      = sop;
        e.eop      = eop;
        for (int p = 0; p < int'(NUM_PKTS); p++) begin
            if (pid == PID_WIDTH'(p)) begin
                e.tmask    = d.tmask[p*EXEC_LANES +: EXEC_LANES];
                e.rs1_data = d.rs1_data[p*EXEC_LANES +: EXEC_LANES];
                e.rs2_data = d.rs2_data[p*EXEC_LANES +: EXEC_LANES];
                e.rs3_data = d.rs3_data[p*EXEC_LANES +: EXEC_LANES];
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/vx_pid_select.sv
// Combinational slice selector: first/last non-empty slice and the next
// non-empty slice above the current pid, via priority encode over masked nz.
module vx_pid_select #(
    parameter int unsigned NP    = 4,
    parameter int unsigned PID_W = 2
) (
    input  logic [NP-1:0]    nz,
    input  logic [PID_W-1:0] pid,
    output logic [PID_W-1:0] first_pid,
    output logic [PID_W-1:0] last_pid,
    output logic [PID_W-1:0] next_pid
);

    logic [NP-1:0] above;

    always_comb begin
        above     = '0;
        first_pid = '0;
        last_pid  = '0;
        next_pid  = '0;
        for (int p = 0; p < int'(NP); p++) begin
            above[p] = nz[p] && (PID_W'(p) > pid);
        end
        // Descending scan so the lowest set bit wins.
        for (int p = int'(NP) - 1; p >= 0; p--) begin
            if (nz[p]) first_pid = PID_W'(p);
            if (above[p]) next_pid = PID_W'(p);
        end
        for (int p = 0; p < int'(NP); p++) begin
            if (nz[p]) last_pid = PID_W'(p);
        end
    end

endmodule

// File: rtl/vx_execute_packetizer.sv
// Slices a full-warp issue packet into NUM_LANES-wide execute packets tagged
// with pid/sop/eop, skipping empty slices; accepts the next warp on eop.
module vx_execute_packetizer
    import vx_execute_packetizer_pkg::*;
#(
    parameter int unsigned NUM_LANES = EXEC_LANES,
    parameter int unsigned OUT_REG   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  issue_data_t   in_data,
    output logic          in_ready,
    output logic          out_valid,
    output execute_data_t out_data,
    input  logic          out_ready
);

    localparam int unsigned NP    = NUM_THREADS / NUM_LANES;
    localparam int unsigned PID_W = PID_WIDTH;

    pkt_state_e       state_q, state_d;
    issue_data_t      hold_q;
    logic [NP-1:0]    nz_q, nz_d, nz_in;
    logic [PID_W-1:0] pid_q, pid_d;
    logic [PID_W-1:0] first_q, last_q, next_q;
    logic [PID_W-1:0] first_in, last_in, next_in_unused;
    logic             load;
    logic             out_fire;
    logic             in_fire;
    logic             eop_cur;

    // Non-empty slice flags of the incoming warp.
    always_comb begin
        nz_in = '0;
        for (int p = 0; p < int'(NP); p++) begin
            nz_in[p] = |in_data.tmask[p*NUM_LANES +: NUM_LANES];
        end
    end

    vx_pid_select #(.NP(NP), .PID_W(PID_W)) u_sel_cur (
        .nz        (nz_q),
        .pid       (pid_q),
        .first_pid (first_q),
        .last_pid  (last_q),
        .next_pid  (next_q)
    );

    vx_pid_select #(.NP(NP), .PID_W(PID_W)) u_sel_in (
        .nz        (nz_in),
        .pid       ('0),
        .first_pid (first_in),
        .last_pid  (last_in),
        .next_pid  (next_in_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            nz_q    <= nz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) hold_q <= in_data;
    end

    // Next state, pid sequencing and the bubble-free accept on eop.
    always_comb begin
        state_d  = state_q;
        pid_d    = pid_q;
        load     = 1'b0;
        eop_cur  = (pid_q == last_q);
        out_fire = (state_q == SEND) && out_ready;
        in_ready = (state_q == IDLE) || (out_fire && eop_cur);
        in_fire  = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = SEND;
                    pid_d   = first_in;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!eop_cur) begin
                        pid_d = next_q;
                    end else if (in_fire) begin
                        pid_d = first_in;
                        load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pid_d   = '0;
                    end
                end
            end
        endcase
        nz_d = load ? nz_in : nz_q;
    end

    if (OUT_REG != 0) begin : g_out_reg
        issue_data_t      hold_d;
        logic [PID_W-1:0] first_d, last_d;
        execute_data_t    data_q;
        logic             valid_q;

        always_comb begin
            hold_d  = load ? in_data  : hold_q;
            first_d = load ? first_in : first_q;
            last_d  = load ? last_in  : last_q;
        end

        // Output flops track the slice the FSM will present next cycle.
        always_ff @(posedge clk) begin
            if (reset) valid_q <= 1'b0;
            else       valid_q <= (state_d == SEND);
        end

        always_ff @(posedge clk) begin
            data_q <= make_slice(hold_d, pid_d, pid_d == first_d, pid_d == last_d);
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end else begin : g_out_comb
        assign out_valid = (state_q == SEND);
        assign out_data  = make_slice(hold_q, pid_q, pid_q == first_q, eop_cur);
    end

endmodule
